// File: rtl/serial_link_pkg.sv
// Shared definitions for both ends of the serial link: FSM states and line levels.
package serial_link_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/serial_frame_receiver.sv
// Serial frame receiver: start bit, WIDTH data bits (LSB- or MSB-first),
// optional even parity, stop bit; word delivered through a one-entry
// valid/ready holding register.
module serial_frame_receiver
  import serial_link_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int PARITY_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_in,
  input  logic             msb_first,
  output logic [WIDTH-1:0] pout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shift;
  logic             order_msb;
  logic             par_bad;

  // Frame FSM, deserialiser and holding-register handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      shift      <= '0;
      order_msb  <= 1'b0;
      par_bad    <= 1'b0;
      pout       <= '0;
      out_valid  <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;

      // Consumption; a good stop below may refill in the same cycle.
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (s_in == START_BIT) begin
            state     <= DATA;
            busy      <= 1'b1;
            order_msb <= msb_first;
            cnt       <= '0;
            par_bad   <= 1'b0;
          end
        end

        DATA: begin
          // Either order leaves the transmitted word in shift after WIDTH bits.
          if (order_msb) begin
            shift <= {shift[WIDTH-2:0], s_in};
          end else begin
            shift <= {s_in, shift[WIDTH-1:1]};
          end
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        PARITY: begin
          par_bad <= s_in ^ (^shift);
          state   <= STOP;
        end

        STOP: begin
          if (s_in == STOP_BIT) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (!out_valid || out_ready) begin
              pout       <= shift;
              parity_err <= par_bad;
              out_valid  <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end else begin
            frame_err <= 1'b1;
            state     <= WAIT_HIGH;
          end
        end

        WAIT_HIGH: begin
          if (s_in == IDLE_LEVEL) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Bench for serial_frame_receiver: directed frames plus randomized frames,
// checked against a frame-level model of the line and the holding register.
module tb_serial_frame_receiver;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         s_in = 1'b1;
  logic         msb_first = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] pout;
  logic         out_valid;
  logic         parity_err;
  logic         frame_err;
  logic         overrun;
  logic         busy;

  int n_cmp = 0;
  int n_err = 0;

  // Model of the holding register.
  logic         m_valid = 1'b0;
  logic [W-1:0] m_word = '0;
  logic         m_perr = 1'b0;

  serial_frame_receiver #(.WIDTH(W), .PARITY_EN(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .s_in       (s_in),
    .msb_first  (msb_first),
    .pout       (pout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One line bit. ev: 0 = ordinary bit, 1 = good stop bit, 2 = bad stop bit.
  task automatic cycle(input logic b, input logic rdy, input logic msb, input int ev,
                       input logic [W-1:0] w, input logic pe, input logic exp_busy);
    logic exp_f;
    logic exp_o;
    @(negedge clk);
    s_in      = b;
    out_ready = rdy;
    msb_first = msb;
    exp_f = 1'b0;
    exp_o = 1'b0;
    if (m_valid && rdy) m_valid = 1'b0;
    if (ev == 1) begin
      if (!m_valid) begin
        m_valid = 1'b1;
        m_word  = w;
        m_perr  = pe;
      end else begin
        exp_o = 1'b1;
      end
    end else if (ev == 2) begin
      exp_f = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    if (m_valid) begin
      chk("pout", {28'd0, pout}, {28'd0, m_word});
      chk("parity_err", {31'd0, parity_err}, {31'd0, m_perr});
    end
    chk("frame_err", {31'd0, frame_err}, {31'd0, exp_f});
    chk("overrun", {31'd0, overrun}, {31'd0, exp_o});
    chk("busy", {31'd0, busy}, {31'd0, exp_busy});
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(1'b1, rdy, 1'b0, 0, '0, 1'b0, 1'b0);
  endtask

  // Sends a whole frame. rdy_mode: 0/1 fixed out_ready, 2 random per bit.
  task automatic send_frame(input logic [W-1:0] w, input logic msb, input logic bad_par,
                            input logic bad_stop, input int hold_low, input int rdy_mode);
    logic r;
    logic par;
    par = (^w) ^ bad_par;
    r = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(rdy_mode);
    cycle(1'b0, r, msb, 0, '0, 1'b0, 1'b1);
    for (int i = 0; i < W; i++) begin
      r = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(rdy_mode);
      cycle(msb ? w[W-1-i] : w[i], r, 1'($urandom_range(0, 1)), 0, '0, 1'b0, 1'b1);
    end
    r = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(rdy_mode);
    cycle(par, r, 1'b0, 0, '0, 1'b0, 1'b1);
    r = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(rdy_mode);
    if (!bad_stop) begin
      cycle(1'b1, r, 1'b0, 1, w, bad_par, 1'b0);
    end else begin
      cycle(1'b0, r, 1'b0, 2, '0, 1'b0, 1'b1);
      for (int i = 0; i < hold_low; i++) begin
        r = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(rdy_mode);
        cycle(1'b0, r, 1'b0, 0, '0, 1'b0, 1'b1);
      end
      r = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(rdy_mode);
      cycle(1'b1, r, 1'b0, 0, '0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_pout", {28'd0, pout}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle(2, 1'b1);

    // LSB-first 1010, good parity
    send_frame(4'b1010, 1'b0, 1'b0, 1'b0, 0, 1);
    idle(1, 1'b1);

    // MSB-first 1101 followed immediately by a second frame
    send_frame(4'b1101, 1'b1, 1'b0, 1'b0, 0, 1);
    send_frame(4'b0110, 1'b1, 1'b0, 1'b0, 0, 1);
    idle(1, 1'b1);

    // Parity error still delivers the word
    send_frame(4'b1010, 1'b0, 1'b1, 1'b0, 0, 1);
    idle(1, 1'b1);

    // Framing error, line held low, then a normal frame
    send_frame(4'b1010, 1'b0, 1'b0, 1'b1, 3, 1);
    idle(1, 1'b1);
    send_frame(4'b0111, 1'b0, 1'b0, 1'b0, 0, 1);
    idle(1, 1'b1);

    // Overrun: consumer stalled across two frames
    idle(1, 1'b0);
    send_frame(4'b0011, 1'b0, 1'b0, 1'b0, 0, 0);
    send_frame(4'b0101, 1'b0, 1'b0, 1'b0, 0, 0);
    idle(2, 1'b0);
    idle(2, 1'b1);

    // Reset mid-DATA with a word pending
    send_frame(4'b1110, 1'b0, 1'b0, 1'b0, 0, 0);
    cycle(1'b0, 1'b0, 1'b0, 0, '0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 0, '0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 0, '0, 1'b0, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    s_in  = 1'b1;
    #1;
    chk("midrst_pout", {28'd0, pout}, 32'd0);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_parity_err", {31'd0, parity_err}, 32'd0);
    m_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    idle(1, 1'b1);
    send_frame(4'b1001, 1'b0, 1'b0, 1'b0, 0, 1);
    idle(1, 1'b1);

    // Randomized frames with random consumer stalls
    for (int f = 0; f < 60; f++) begin
      logic [W-1:0] w;
      logic bp;
      logic bs;
      w  = W'($urandom);
      bp = ($urandom_range(0, 4) == 0);
      bs = ($urandom_range(0, 5) == 0);
      send_frame(w, 1'($urandom_range(0, 1)), bp, bs, int'($urandom_range(0, 3)), 2);
      idle(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end
    idle(2, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
